// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: 8N1 LSB-first serialiser for the car command byte.
// A frame is sent whenever cmd_in differs from the last byte sent. The current
// command is also re-sent as a keep-alive after REFRESH_CYCLES idle cycles.
module uart_cmd_tx #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] cmd_in,
  output logic       txd,
  output logic       busy,
  output logic       frame_sent
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int RW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam bit REF_EN = (REFRESH_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [RW-1:0] refresh_cnt, ref_n;
  logic [7:0]    shift_reg, shift_n;
  logic [7:0]    last_sent, last_n;
  logic          first_flag, first_n;
  logic          txd_n, busy_n, fs_n;
  logic          launch, baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  // Only the keep-alive term depends on REFRESH_CYCLES; with 0 it never fires.
  assign launch = enable & (first_flag | (cmd_in != last_sent) |
                            (REF_EN & (refresh_cnt == REF_LAST)));

  // Next-state and next-output logic; txd is computed for the upcoming state so it leaves a flop.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    ref_n   = refresh_cnt;
    shift_n = shift_reg;
    last_n  = last_sent;
    first_n = first_flag;
    txd_n   = 1'b1;
    busy_n  = busy;
    fs_n    = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_cnt != REF_LAST) ref_n = refresh_cnt + 1'b1;
        if (launch) begin
          shift_n = cmd_in;
          last_n  = cmd_in;
          first_n = 1'b0;
          ref_n   = '0;
          baud_n  = '0;
          busy_n  = 1'b1;
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        txd_n = 1'b0;
        if (baud_wrap) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = DATA;
          txd_n   = shift_reg[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        txd_n = shift_reg[bit_idx];
        if (baud_wrap) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            txd_n = shift_reg[bit_n];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        txd_n = 1'b1;
        if (baud_wrap) begin
          baud_n  = '0;
          state_n = IDLE;
          busy_n  = 1'b0;
          fs_n    = 1'b1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame and returns the line to idle-high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= 3'd0;
      refresh_cnt <= '0;
      shift_reg   <= 8'h00;
      last_sent   <= 8'h00;
      first_flag  <= 1'b1;
      txd         <= 1'b1;
      busy        <= 1'b0;
      frame_sent  <= 1'b0;
    end else begin
      state       <= state_n;
      baud_cnt    <= baud_n;
      bit_idx     <= bit_n;
      refresh_cnt <= ref_n;
      shift_reg   <= shift_n;
      last_sent   <= last_n;
      first_flag  <= first_n;
      txd         <= txd_n;
      busy        <= busy_n;
      frame_sent  <= fs_n;
    end
  end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb_uart_cmd_tx: scenario tasks against a line-level frame decoder and arithmetic timing rules.
module tb_uart_cmd_tx;

  localparam int CPB  = 16;
  localparam int REF  = 200;
  localparam int FLEN = 10 * CPB;

  typedef struct {
    int         st;
    int         fs;
    logic [7:0] data;
    bit         clean;
    bit         bok;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] cmd_in = 8'h81;
  logic       txd, busy, frame_sent;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fs = 0;

  frame_t frames[$];
  int     fs_q[$];
  bit     mon_act = 1'b0;
  int     mon_st = 0;

  uart_cmd_tx #(.CLK_FREQ(16), .BAUD(1), .REFRESH_CYCLES(REF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_in(cmd_in),
    .txd(txd), .busy(busy), .frame_sent(frame_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: a low txd while idle opens a frame; 160 samples are then decoded as 8N1.
  initial begin
    logic   smp [FLEN];
    int     pos;
    bit     rst_prev;
    bit     bok;
    frame_t f;
    pos = 0; rst_prev = 1'b0; bok = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_prev) mon_act = 1'b0;
      else begin
        if (frame_sent === 1'b1) fs_q.push_back(cyc);
        if (mon_act) begin
          smp[pos] = txd;
          if (busy !== 1'b1) bok = 1'b0;
          pos++;
          if (pos == FLEN) begin
            f.st = mon_st; f.fs = 0; f.bok = bok; f.clean = 1'b1; f.data = 8'h00;
            for (int i = 0; i < FLEN; i++) begin
              logic eb;
              if (i < CPB) eb = 1'b0;
              else if (i >= 9 * CPB) eb = 1'b1;
              else eb = smp[CPB * (i / CPB)];
              if (smp[i] !== eb) f.clean = 1'b0;
            end
            for (int k = 0; k < 8; k++) f.data[k] = smp[CPB * (k + 1) + CPB / 2];
            frames.push_back(f);
            mon_act = 1'b0;
          end
        end else if (txd === 1'b0) begin
          mon_act = 1'b1; mon_st = cyc; pos = 1; smp[0] = txd; bok = (busy === 1'b1);
        end
      end
      rst_prev = rst_n;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic get_frame(output frame_t f, output bit ok);
    int n = 0;
    while ((frames.size() == 0 || fs_q.size() == 0) && n < 800) begin
      @(negedge clk); #1; n++;
    end
    ok = (frames.size() != 0 && fs_q.size() != 0);
    f = '{st: 0, fs: 0, data: 8'h00, clean: 1'b0, bok: 1'b0};
    if (ok) begin
      f = frames.pop_front();
      f.fs = fs_q.pop_front();
    end
  endtask

  task automatic wait_start(output bit ok, output int st);
    int n = 0;
    while (!mon_act && n < 800) begin
      @(negedge clk); #1; n++;
    end
    ok = mon_act;
    st = mon_st;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frame_sent !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_sent); end
  endtask

  task automatic test_first_frame();
    frame_t f; bit ok; int rel;
    @(posedge clk); #1; rst_n = 1'b1; rel = cyc;
    get_frame(f, ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_timeout got none exp frame"); end
    else begin
      checks++; if (f.st != rel + 1) begin errors++; $display("FAIL first_latency got %0d exp %0d", f.st - rel, 1); end
      checks++; if (f.data !== 8'h81) begin errors++; $display("FAIL first_data got %h exp 81", f.data); end
      checks++; if (!f.clean) begin errors++; $display("FAIL first_shape got 0 exp 1"); end
      checks++; if (!f.bok) begin errors++; $display("FAIL first_busy got 0 exp 1"); end
      checks++; if (f.fs != f.st + FLEN) begin errors++; $display("FAIL first_len got %0d exp %0d", f.fs - f.st, FLEN); end
      last_fs = f.fs;
    end
  endtask

  task automatic test_keepalive();
    frame_t f; bit ok;
    get_frame(f, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ka_timeout got none exp frame"); end
    else begin
      checks++; if (f.st != last_fs + REF) begin errors++; $display("FAIL ka_gap got %0d exp %0d", f.st - last_fs, REF); end
      checks++; if (f.data !== 8'h81 || !f.clean) begin errors++; $display("FAIL ka_data got %h clean %0d exp 81", f.data, f.clean); end
      last_fs = f.fs;
    end
  endtask

  task automatic test_change_mid();
    frame_t f1, f2; bit ok1, ok2; int st;
    wait_start(ok1, st);
    checks++; if (!ok1 || st != last_fs + REF) begin errors++; $display("FAIL cm_ka_start got %0d exp %0d", st - last_fs, REF); end
    while (cyc < st + 64) begin @(posedge clk); #1; end
    cmd_in = 8'h85;
    get_frame(f1, ok1);
    get_frame(f2, ok2);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL cm_timeout got %0d%0d exp 11", ok1, ok2); end
    else begin
      checks++; if (f1.data !== 8'h81) begin errors++; $display("FAIL cm_first got %h exp 81", f1.data); end
      checks++; if (f2.data !== 8'h85 || !f2.clean) begin errors++; $display("FAIL cm_second got %h exp 85", f2.data); end
      checks++; if (f2.st != f1.fs + 1) begin errors++; $display("FAIL cm_idle_gap got %0d exp 1", f2.st - f1.fs); end
      last_fs = f2.fs;
    end
    repeat (40) @(negedge clk);
    #1;
    checks++; if (frames.size() != 0 || fs_q.size() != 0) begin errors++; $display("FAIL cm_extra got %0d exp 0", fs_q.size()); end
  endtask

  task automatic test_glitch();
    frame_t f, f2; bit ok, ok2; int c, st;
    @(posedge clk); #1; cmd_in = 8'h81; c = cyc;
    wait_start(ok, st);
    checks++; if (!ok || st != c + 1) begin errors++; $display("FAIL gl_start got %0d exp %0d", st, c + 1); end
    while (cyc < st + 30) begin @(posedge clk); #1; end
    cmd_in = 8'h85;
    while (cyc < st + 150) begin @(posedge clk); #1; end
    cmd_in = 8'h81;
    get_frame(f, ok);
    get_frame(f2, ok2);
    checks++; if (!ok || !ok2) begin errors++; $display("FAIL gl_timeout got %0d%0d exp 11", ok, ok2); end
    else begin
      checks++; if (f.data !== 8'h81) begin errors++; $display("FAIL gl_data got %h exp 81", f.data); end
      checks++; if (f2.st != f.fs + REF || f2.data !== 8'h81) begin errors++; $display("FAIL gl_next got gap %0d data %h exp gap %0d data 81", f2.st - f.fs, f2.data, REF); end
      last_fs = f2.fs;
    end
  endtask

  task automatic test_reset_mid();
    frame_t f; bit ok; int c, st, rel;
    logic [7:0] x;
    do x = 8'($urandom); while (x == 8'h81 || x == 8'h00);
    @(posedge clk); #1; cmd_in = x; c = cyc;
    wait_start(ok, st);
    checks++; if (!ok || st != c + 1) begin errors++; $display("FAIL rm_start got %0d exp %0d", st, c + 1); end
    while (cyc < st + 84) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; rel = cyc;
    @(negedge clk);
    checks++; if (txd !== 1'b1 || busy !== 1'b0 || frame_sent !== 1'b0) begin errors++; $display("FAIL rm_abort got txd %b busy %b fs %b exp 1 0 0", txd, busy, frame_sent); end
    get_frame(f, ok);
    checks++; if (!ok || f.st != rel + 1 || f.data !== x || !f.clean) begin errors++; $display("FAIL rm_resend got st %0d data %h exp st %0d data %h", f.st, f.data, rel + 1, x); end
    // Reset with cmd_in equal to the post-reset last_sent value: only first_flag can launch it.
    @(posedge clk); #1; rst_n = 1'b0; cmd_in = 8'h00;
    @(posedge clk); #1; rst_n = 1'b1; rel = cyc;
    get_frame(f, ok);
    checks++; if (!ok || f.st != rel + 1 || f.data !== 8'h00) begin errors++; $display("FAIL rm_first_flag got st %0d data %h exp st %0d data 00", f.st, f.data, rel + 1); end
    last_fs = f.fs;
  endtask

  task automatic test_enable();
    frame_t f, f2; bit ok, ok2, quiet; int e;
    @(posedge clk); #1; enable = 1'b0; cmd_in = 8'h82;
    quiet = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    #1;
    checks++; if (!quiet || frames.size() != 0) begin errors++; $display("FAIL en_quiet got activity exp idle"); end
    @(posedge clk); #1; enable = 1'b1; e = cyc;
    get_frame(f, ok);
    get_frame(f2, ok2);
    checks++; if (!ok || !ok2) begin errors++; $display("FAIL en_timeout got %0d%0d exp 11", ok, ok2); end
    else begin
      checks++; if (f.st != e + 1 || f.data !== 8'h82) begin errors++; $display("FAIL en_launch got st %0d data %h exp st %0d data 82", f.st, f.data, e + 1); end
      checks++; if (f2.st != f.fs + REF || f2.data !== 8'h82) begin errors++; $display("FAIL en_refresh got gap %0d exp %0d", f2.st - f.fs, REF); end
      last_fs = f2.fs;
    end
  endtask

  task automatic test_random();
    logic [7:0] cur;
    cur = cmd_in;
    for (int it = 0; it < 6; it++) begin
      logic [7:0] b1, b2;
      int d, c, o, st;
      bit ok, ok2, mid;
      frame_t f, f2;
      do b1 = 8'($urandom); while (b1 == cur);
      d = $urandom_range(1, 150);
      while (cyc < last_fs + d) begin @(posedge clk); #1; end
      cmd_in = b1; c = cyc;
      wait_start(ok, st);
      checks++; if (!ok || st != c + 1) begin errors++; $display("FAIL rnd_start it %0d got %0d exp %0d", it, st, c + 1); end
      mid = 1'($urandom_range(0, 1));
      b2 = b1;
      if (mid) begin
        do b2 = 8'($urandom); while (b2 == b1);
        o = $urandom_range(1, 150);
        while (cyc < st + o) begin @(posedge clk); #1; end
        cmd_in = b2;
      end
      get_frame(f, ok);
      checks++; if (!ok || f.data !== b1 || !f.clean || f.fs != f.st + FLEN) begin errors++; $display("FAIL rnd_frame it %0d got %h exp %h", it, f.data, b1); end
      last_fs = f.fs;
      if (mid) begin
        get_frame(f2, ok2);
        checks++; if (!ok2 || f2.data !== b2 || f2.st != f.fs + 1) begin errors++; $display("FAIL rnd_b2b it %0d got %h gap %0d exp %h gap 1", it, f2.data, f2.st - f.fs, b2); end
        last_fs = f2.fs;
      end
      cur = b2;
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_keepalive();
    test_change_mid();
    test_glitch();
    test_reset_mid();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
